// File: rtl/instr_pkg.sv
// Shared types and defaults for the chiplet link controller.
// Holds the instruction/response payload structs, the link state enum and
// default sizing constants used by chiplet_link_ctrl and its testbench.
package instr_pkg;

    localparam int unsigned DEF_INSTR_FIFO_DEPTH = 4;
    localparam int unsigned DEF_RESP_FIFO_DEPTH  = 2;
    localparam int unsigned DEF_MAX_OUTSTANDING  = 8;

    // CPU -> NMCU instruction payload
    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] addr;
        logic [31:0] data;
    } instruction_t;

    // NMCU -> CPU response payload
    typedef struct packed {
        logic [7:0]  tag;
        logic [1:0]  status;
        logic [31:0] data;
    } nmcu_cpu_resp_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        DRAIN   = 2'd2,
        DRAINED = 2'd3
    } link_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, parameterised by payload type and depth.
// Ports:
//   clk, rst_n   clock, async active-low reset (empties the FIFO)
//   push_i       write wdata_i (ignored when full)
//   wdata_i      write payload
//   pop_i        drop the head entry (ignored when empty)
//   rdata_o      head entry (valid whenever count_o != 0)
//   count_o      number of stored entries
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module sync_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  T              wdata_i,
    input  logic          pop_i,
    output T              rdata_o,
    output logic [CW-1:0] count_o
);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i && (count_q != CW'(DEPTH));
    assign pop_ok  = pop_i  && (count_q != '0);

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap modulo DEPTH through their natural width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/chiplet_link_ctrl.sv
// Chiplet link controller: buffers CPU instructions toward the NMCU core and
// core responses back to the CPU, tracks outstanding work, and supports a
// drain handshake that quiesces the link.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cpu_instr_*                        CPU instruction valid/ready/payload
//   core_instr_*                       instruction toward NMCU core
//   core_resp_*                        response from NMCU core
//   nmcu_resp_*                        response toward CPU
//   drain_req / drain_done             quiesce request (level) / link quiesced
//   outstanding_cnt                    accepted instructions not yet answered
//   proto_err                          sticky: response with nothing outstanding
//   perf_instr_cnt / perf_stall_cnt    performance counters
// Optional feature macro: NMCU_LINK_PERF_EN enables the perf counters;
// without it both perf outputs are tied to zero.
module chiplet_link_ctrl
    import instr_pkg::*;
#(
    parameter int unsigned INSTR_FIFO_DEPTH = DEF_INSTR_FIFO_DEPTH,
    parameter int unsigned RESP_FIFO_DEPTH  = DEF_RESP_FIFO_DEPTH,
    parameter int unsigned MAX_OUTSTANDING  = DEF_MAX_OUTSTANDING
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cpu_instr_valid,
    output logic           cpu_instr_ready,
    input  instruction_t   cpu_instruction,
    output logic           core_instr_valid,
    input  logic           core_instr_ready,
    output instruction_t   core_instruction,
    input  logic           core_resp_valid,
    output logic           core_resp_ready,
    input  nmcu_cpu_resp_t core_response,
    output logic           nmcu_resp_valid,
    input  logic           nmcu_resp_ready,
    output nmcu_cpu_resp_t nmcu_response,
    input  logic           drain_req,
    output logic           drain_done,
    output logic [7:0]     outstanding_cnt,
    output logic           proto_err,
    output logic [31:0]    perf_instr_cnt,
    output logic [31:0]    perf_stall_cnt
);

    localparam int unsigned ICW = $clog2(INSTR_FIFO_DEPTH + 1);
    localparam int unsigned RCW = $clog2(RESP_FIFO_DEPTH + 1);

    link_state_t    state_q, state_d;
    logic           cpu_ready_q, cpu_ready_d;
    logic           resp_ready_q, resp_ready_d;
    logic           drain_done_q, drain_done_d;
    logic           proto_err_q, proto_err_d;
    logic [7:0]     out_cnt_q, out_cnt_d;

    logic [ICW-1:0] in_cnt, in_cnt_d;
    logic [RCW-1:0] resp_cnt, resp_cnt_d;
    logic           cpu_hs, core_hs, core_resp_hs, nmcu_hs;
    logic           link_empty;

    // Handshakes; drain_req masks CPU ready in the same cycle it rises.
    assign cpu_instr_ready  = cpu_ready_q && !drain_req;
    assign cpu_hs           = cpu_instr_valid && cpu_instr_ready;
    assign core_instr_valid = (in_cnt != '0);
    assign core_hs          = core_instr_valid && core_instr_ready;
    assign core_resp_ready  = resp_ready_q;
    assign core_resp_hs     = core_resp_valid && resp_ready_q;
    assign nmcu_resp_valid  = (resp_cnt != '0);
    assign nmcu_hs          = nmcu_resp_valid && nmcu_resp_ready;

    sync_fifo #(
        .T     (instruction_t),
        .DEPTH (INSTR_FIFO_DEPTH)
    ) u_instr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cpu_hs),
        .wdata_i (cpu_instruction),
        .pop_i   (core_hs),
        .rdata_o (core_instruction),
        .count_o (in_cnt)
    );

    sync_fifo #(
        .T     (nmcu_cpu_resp_t),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (core_resp_hs),
        .wdata_i (core_response),
        .pop_i   (nmcu_hs),
        .rdata_o (nmcu_response),
        .count_o (resp_cnt)
    );

    assign link_empty = (out_cnt_q == '0) && (in_cnt == '0) && (resp_cnt == '0);

    // Next FIFO occupancy; the registered readies are precomputed from it.
    assign in_cnt_d   = in_cnt   + ICW'(cpu_hs)       - ICW'(core_hs);
    assign resp_cnt_d = resp_cnt + RCW'(core_resp_hs) - RCW'(nmcu_hs);

    // Outstanding counter, protocol error and state/ready next values.
    always_comb begin
        state_d      = state_q;
        out_cnt_d    = out_cnt_q;
        proto_err_d  = proto_err_q;

        if (cpu_hs && !nmcu_hs) begin
            out_cnt_d = out_cnt_q + 8'd1;
        end else if (!cpu_hs && nmcu_hs && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - 8'd1;
        end

        if (core_resp_hs && (out_cnt_q == '0) && !cpu_hs) begin
            proto_err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end else if (cpu_hs) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end else if (link_empty && !cpu_hs) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (link_empty) begin
                    state_d = DRAINED;
                end
            end
            DRAINED: begin
                if (!drain_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cpu_ready_d  = ((state_d == IDLE) || (state_d == ACTIVE))
                    && (in_cnt_d < ICW'(INSTR_FIFO_DEPTH))
                    && (out_cnt_d < 8'(MAX_OUTSTANDING));
        resp_ready_d = (resp_cnt_d < RCW'(RESP_FIFO_DEPTH));
        drain_done_d = (state_d == DRAINED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_cnt_q    <= '0;
            proto_err_q  <= 1'b0;
            cpu_ready_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_cnt_q    <= out_cnt_d;
            proto_err_q  <= proto_err_d;
            cpu_ready_q  <= cpu_ready_d;
            resp_ready_q <= resp_ready_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign outstanding_cnt = out_cnt_q;
    assign proto_err       = proto_err_q;
    assign drain_done      = drain_done_q;

`ifdef NMCU_LINK_PERF_EN
    logic [31:0] perf_instr_q;
    logic [31:0] perf_stall_q;

    // Free-running wrap-around counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_instr_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (cpu_hs) begin
                perf_instr_q <= perf_instr_q + 32'd1;
            end
            if (cpu_instr_valid && !cpu_instr_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_instr_cnt = perf_instr_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_instr_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_chiplet_link_ctrl.sv
// Self-checking bench for chiplet_link_ctrl: table-driven backpressure
// vectors plus directed sequences for latency, outstanding limit, protocol
// error, drain and asynchronous reset. A second instance with
// MAX_OUTSTANDING=2 shares the inputs and is observed only in its own phase.
module tb_chiplet_link_ctrl;
    import instr_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cpu_instr_valid;
    instruction_t   cpu_instruction;
    logic           core_instr_ready;
    logic           core_resp_valid;
    nmcu_cpu_resp_t core_response;
    logic           nmcu_resp_ready;
    logic           drain_req;

    logic           a_cpu_ready, a_core_valid, a_core_resp_ready, a_nmcu_valid;
    logic           a_drain_done, a_proto_err;
    instruction_t   a_core_instr;
    nmcu_cpu_resp_t a_nmcu_resp;
    logic [7:0]     a_out_cnt;
    logic [31:0]    a_perf_instr, a_perf_stall;

    logic           b_cpu_ready, b_core_valid, b_core_resp_ready, b_nmcu_valid;
    logic           b_drain_done, b_proto_err;
    instruction_t   b_core_instr;
    nmcu_cpu_resp_t b_nmcu_resp;
    logic [7:0]     b_out_cnt;
    logic [31:0]    b_perf_instr, b_perf_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chiplet_link_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpu_instr_valid  (cpu_instr_valid),
        .cpu_instr_ready  (a_cpu_ready),
        .cpu_instruction  (cpu_instruction),
        .core_instr_valid (a_core_valid),
        .core_instr_ready (core_instr_ready),
        .core_instruction (a_core_instr),
        .core_resp_valid  (core_resp_valid),
        .core_resp_ready  (a_core_resp_ready),
        .core_response    (core_response),
        .nmcu_resp_valid  (a_nmcu_valid),
        .nmcu_resp_ready  (nmcu_resp_ready),
        .nmcu_response    (a_nmcu_resp),
        .drain_req        (drain_req),
        .drain_done       (a_drain_done),
        .outstanding_cnt  (a_out_cnt),
        .proto_err        (a_proto_err),
        .perf_instr_cnt   (a_perf_instr),
        .perf_stall_cnt   (a_perf_stall)
    );

    chiplet_link_ctrl #(.MAX_OUTSTANDING(2)) dut_m2 (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpu_instr_valid  (cpu_instr_valid),
        .cpu_instr_ready  (b_cpu_ready),
        .cpu_instruction  (cpu_instruction),
        .core_instr_valid (b_core_valid),
        .core_instr_ready (core_instr_ready),
        .core_instruction (b_core_instr),
        .core_resp_valid  (core_resp_valid),
        .core_resp_ready  (b_core_resp_ready),
        .core_response    (core_response),
        .nmcu_resp_valid  (b_nmcu_valid),
        .nmcu_resp_ready  (nmcu_resp_ready),
        .nmcu_response    (b_nmcu_resp),
        .drain_req        (drain_req),
        .drain_done       (b_drain_done),
        .outstanding_cnt  (b_out_cnt),
        .proto_err        (b_proto_err),
        .perf_instr_cnt   (b_perf_instr),
        .perf_stall_cnt   (b_perf_stall)
    );

    typedef struct {
        logic       valid;
        logic [7:0] tag;
        logic       core_ready;
        logic       exp_ready;
        logic       exp_cvalid;
        logic [7:0] exp_out;
        logic [7:0] exp_head;
    } vec_t;

    vec_t tbl [9];

    function automatic instruction_t mk_instr(input logic [7:0] t);
        instruction_t r;
        r.opcode = t ^ 8'h5A;
        r.addr   = {16'hA000, t};
        r.data   = {4{t}};
        return r;
    endfunction

    function automatic nmcu_cpu_resp_t mk_resp(input logic [7:0] t);
        nmcu_cpu_resp_t r;
        r.tag    = t;
        r.status = t[1:0];
        r.data   = {t, 8'hC3, t, 8'h3C};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reset both instances; returns at a negedge with the first post-reset edge done.
    task automatic do_reset();
        cpu_instr_valid  = 1'b0;
        cpu_instruction  = '0;
        core_instr_ready = 1'b0;
        core_resp_valid  = 1'b0;
        core_response    = '0;
        nmcu_resp_ready  = 1'b0;
        drain_req        = 1'b0;
        rst_n            = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_before_edge", 64'(a_cpu_ready), 64'd0);
        chk("rst_resp_ready_before_edge", 64'(a_core_resp_ready), 64'd0);
        @(negedge clk);
        chk("rst_ready_after_edge", 64'(a_cpu_ready), 64'd1);
        chk("rst_resp_ready_after_edge", 64'(a_core_resp_ready), 64'd1);
        chk("rst_out_cnt", 64'(a_out_cnt), 64'd0);
        chk("rst_core_valid", 64'(a_core_valid), 64'd0);
        chk("rst_nmcu_valid", 64'(a_nmcu_valid), 64'd0);
        chk("rst_drain_done", 64'(a_drain_done), 64'd0);
        chk("rst_proto_err", 64'(a_proto_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned exp_pi;
        int unsigned exp_ps;
        int n;

        //            valid tag    crdy  rdy cval out  head
        tbl[0] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'd1, 8'h10};
        tbl[1] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'd2, 8'h10};
        tbl[2] = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'd3, 8'h10};
        tbl[3] = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'd4, 8'h10};
        tbl[4] = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 8'd4, 8'h10};
        tbl[5] = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 8'd4, 8'h10};
        tbl[6] = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b1, 8'd4, 8'h11};
        tbl[7] = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 8'd5, 8'h11};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd5, 8'h11};

        rst_n = 1'b1;
        #3;

        // Single instruction: 1-cycle ingress latency.
        do_reset();
        cpu_instr_valid  = 1'b1;
        cpu_instruction  = mk_instr(8'hA0);
        core_instr_ready = 1'b1;
        @(negedge clk);
        chk("lat_core_valid", 64'(a_core_valid), 64'd1);
        chk("lat_payload", 64'(a_core_instr), 64'(mk_instr(8'hA0)));
        chk("lat_out_cnt", 64'(a_out_cnt), 64'd1);
        cpu_instr_valid = 1'b0;
        @(negedge clk);
        chk("lat_popped", 64'(a_core_valid), 64'd0);
        chk("lat_out_hold", 64'(a_out_cnt), 64'd1);

        // Ingress backpressure with a stalled core.
        do_reset();
        nmcu_resp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cpu_instr_valid  = tbl[i].valid;
            cpu_instruction  = mk_instr(tbl[i].tag);
            core_instr_ready = tbl[i].core_ready;
            @(negedge clk);
            chk($sformatf("bp%0d_ready", i), 64'(a_cpu_ready), 64'(tbl[i].exp_ready));
            chk($sformatf("bp%0d_cvalid", i), 64'(a_core_valid), 64'(tbl[i].exp_cvalid));
            chk($sformatf("bp%0d_out", i), 64'(a_out_cnt), 64'(tbl[i].exp_out));
            chk($sformatf("bp%0d_head", i), 64'(a_core_instr), 64'(mk_instr(tbl[i].exp_head)));
        end
`ifdef NMCU_LINK_PERF_EN
        exp_pi = 5;
        exp_ps = 3;
`else
        exp_pi = 0;
        exp_ps = 0;
`endif
        chk("perf_instr", 64'(a_perf_instr), 64'(exp_pi));
        chk("perf_stall", 64'(a_perf_stall), 64'(exp_ps));
        cpu_instr_valid  = 1'b0;
        core_instr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("order%0d", k), 64'(a_core_instr), 64'(mk_instr(8'(8'h10 + k))));
            @(negedge clk);
        end
        chk("order_empty", 64'(a_core_valid), 64'd0);

        // Outstanding limit of 2 on the second instance.
        do_reset();
        core_instr_ready = 1'b1;
        cpu_instr_valid  = 1'b1;
        cpu_instruction  = mk_instr(8'h20);
        @(negedge clk);
        chk("m2_out1", 64'(b_out_cnt), 64'd1);
        chk("m2_ready1", 64'(b_cpu_ready), 64'd1);
        cpu_instruction = mk_instr(8'h21);
        @(negedge clk);
        chk("m2_out2", 64'(b_out_cnt), 64'd2);
        chk("m2_ready_full", 64'(b_cpu_ready), 64'd0);
        cpu_instruction = mk_instr(8'h22);
        @(negedge clk);
        chk("m2_stall", 64'(b_cpu_ready), 64'd0);
        chk("m2_stall_out", 64'(b_out_cnt), 64'd2);
        core_resp_valid = 1'b1;
        core_response   = mk_resp(8'h20);
        @(negedge clk);
        core_resp_valid = 1'b0;
        chk("m2_resp_valid", 64'(b_nmcu_valid), 64'd1);
        chk("m2_resp_data", 64'(b_nmcu_resp), 64'(mk_resp(8'h20)));
        chk("m2_out_still2", 64'(b_out_cnt), 64'd2);
        nmcu_resp_ready = 1'b1;
        @(negedge clk);
        nmcu_resp_ready = 1'b0;
        chk("m2_out_dec", 64'(b_out_cnt), 64'd1);
        chk("m2_ready_back", 64'(b_cpu_ready), 64'd1);
        @(negedge clk);
        chk("m2_out_reinc", 64'(b_out_cnt), 64'd2);
        chk("m2_third_head", 64'(b_core_valid), 64'd1);
        cpu_instr_valid = 1'b0;

        // Response with nothing outstanding.
        do_reset();
        core_resp_valid = 1'b1;
        core_response   = mk_resp(8'h55);
        @(negedge clk);
        core_resp_valid = 1'b0;
        chk("perr_set", 64'(a_proto_err), 64'd1);
        chk("perr_resp_valid", 64'(a_nmcu_valid), 64'd1);
        chk("perr_resp_data", 64'(a_nmcu_resp), 64'(mk_resp(8'h55)));
        chk("perr_out0", 64'(a_out_cnt), 64'd0);
        nmcu_resp_ready = 1'b1;
        @(negedge clk);
        chk("perr_delivered", 64'(a_nmcu_valid), 64'd0);
        chk("perr_out_sat", 64'(a_out_cnt), 64'd0);
        repeat (3) @(negedge clk);
        chk("perr_sticky", 64'(a_proto_err), 64'd1);

        // Drain with 3 outstanding.
        do_reset();
        core_instr_ready = 1'b1;
        nmcu_resp_ready  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cpu_instr_valid = 1'b1;
            cpu_instruction = mk_instr(8'(8'h30 + k));
            @(negedge clk);
        end
        chk("drain_out3", 64'(a_out_cnt), 64'd3);
        cpu_instruction = mk_instr(8'h33);
        drain_req       = 1'b1;
        #1;
        chk("drain_ready_immediate", 64'(a_cpu_ready), 64'd0);
        @(negedge clk);
        chk("drain_out_hold", 64'(a_out_cnt), 64'd3);
        chk("drain_not_done", 64'(a_drain_done), 64'd0);
        for (int k = 0; k < 3; k++) begin
            core_resp_valid = 1'b1;
            core_response   = mk_resp(8'(8'h30 + k));
            @(negedge clk);
        end
        core_resp_valid = 1'b0;
        n = 0;
        while (!a_drain_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 64'(a_drain_done), 64'd1);
        chk("drain_out0", 64'(a_out_cnt), 64'd0);
        chk("drain_ready_low", 64'(a_cpu_ready), 64'd0);
        drain_req = 1'b0;
        @(negedge clk);
        chk("undrain_done_low", 64'(a_drain_done), 64'd0);
        chk("undrain_ready", 64'(a_cpu_ready), 64'd1);
        @(negedge clk);
        chk("undrain_accept", 64'(a_out_cnt), 64'd1);
        cpu_instr_valid = 1'b0;

        // Asynchronous reset with both FIFOs occupied.
        do_reset();
        cpu_instr_valid = 1'b1;
        cpu_instruction = mk_instr(8'h40);
        @(negedge clk);
        cpu_instruction = mk_instr(8'h41);
        @(negedge clk);
        cpu_instr_valid = 1'b0;
        core_resp_valid = 1'b1;
        core_response   = mk_resp(8'h40);
        @(negedge clk);
        core_resp_valid = 1'b0;
        chk("ar_pre_cvalid", 64'(a_core_valid), 64'd1);
        chk("ar_pre_nvalid", 64'(a_nmcu_valid), 64'd1);
        chk("ar_pre_out", 64'(a_out_cnt), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cvalid", 64'(a_core_valid), 64'd0);
        chk("ar_nvalid", 64'(a_nmcu_valid), 64'd0);
        chk("ar_out", 64'(a_out_cnt), 64'd0);
        chk("ar_ready", 64'(a_cpu_ready), 64'd0);
        chk("ar_resp_ready", 64'(a_core_resp_ready), 64'd0);
        chk("ar_perf_instr", 64'(a_perf_instr), 64'd0);
        chk("ar_perf_stall", 64'(a_perf_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ar_stale_c%0d", k), 64'(a_core_valid), 64'd0);
            chk($sformatf("ar_stale_n%0d", k), 64'(a_nmcu_valid), 64'd0);
        end
        chk("ar_ready_back", 64'(a_cpu_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chiplet_link_ctrl.md
CHIPLET_LINK_CTRL -- requirements
Module: chiplet_link_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 Parameters SHALL be:
- INSTR_FIFO_DEPTH, default 4: ingress FIFO entries; power of 2, at least 2.
- RESP_FIFO_DEPTH, default 2: response FIFO entries; power of 2, at least 2.
- MAX_OUTSTANDING, default 8: limit on accepted instructions whose response has not yet been delivered; range 1..255.
REQ-003 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- cpu_instr_valid  in  1  CPU instruction valid.
- cpu_instr_ready  out  1  instruction accepted this cycle if valid.
- cpu_instruction  in  instr_pkg::instruction_t  instruction payload.
- core_instr_valid  out  1  instruction offered to NMCU core.
- core_instr_ready  in  1  core accepts.
- core_instruction  out  instr_pkg::instruction_t  head of ingress FIFO.
- core_resp_valid  in  1  core response valid.
- core_resp_ready  out  1  response FIFO not full.
- core_response  in  instr_pkg::nmcu_cpu_resp_t  core response payload.
- nmcu_resp_valid  out  1  response to CPU valid.
- nmcu_resp_ready  in  1  CPU accepts response.
- nmcu_response  out  instr_pkg::nmcu_cpu_resp_t  head of response FIFO.
- drain_req  in  1  level request to quiesce the link.
- drain_done  out  1  link quiesced.
- outstanding_cnt  out  8  current outstanding count.
- proto_err  out  1  sticky: response arrived with zero outstanding.
- perf_instr_cnt  out  32  accepted-instruction counter.
- perf_stall_cnt  out  32  CPU backpressure-cycle counter.

Function
REQ-004 A handshake SHALL complete on any clk edge where valid and ready are both high; valid, once asserted, is held with stable payload until the handshake.
REQ-005 cpu_instr_ready SHALL be high iff state is IDLE or ACTIVE, ingress FIFO is not full, and outstanding_cnt < MAX_OUTSTANDING.
REQ-006 cpu_instr_ready SHALL NOT depend combinationally on core_instr_ready; a full FIFO blocks push even when a pop occurs in the same cycle.
REQ-007 core_instr_valid SHALL equal "ingress FIFO not empty", with core_instruction driven from the FIFO head.
REQ-008 Ingress latency SHALL be 1 cycle: an instruction accepted at edge N appears at the core at N+1. There is no bypass path, and order is preserved.
REQ-009 core_resp_ready SHALL equal "response FIFO not full"; nmcu_resp_valid SHALL equal "response FIFO not empty"; response latency SHALL be 1 cycle, in order.
REQ-010 outstanding_cnt SHALL update as follows:
- +1 on a CPU instruction handshake.
- -1 on an nmcu_resp handshake.
- Unchanged when both occur in the same cycle.
REQ-011 A core response handshake while outstanding_cnt == 0 and no CPU handshake is in progress SHALL set proto_err, which is sticky until reset. The response is still queued, and the decrement saturates at 0.
REQ-012 The state machine SHALL have states IDLE, ACTIVE, DRAIN and DRAINED, with these transitions:
- IDLE -> ACTIVE on a CPU handshake.
- ACTIVE -> IDLE when outstanding_cnt == 0 and both FIFOs are empty.
- IDLE or ACTIVE -> DRAIN when drain_req is high; drain_req has priority over a CPU handshake in the same cycle, and that handshake cannot occur because ready is low.
- DRAIN -> DRAINED when outstanding_cnt == 0 and both FIFOs are empty.
- DRAINED -> IDLE when drain_req is low.
REQ-013 drain_done SHALL be high exactly in state DRAINED.
REQ-014 In DRAIN the core and response paths SHALL keep operating normally.
REQ-015 FIFO pointers SHALL wrap modulo depth. Each FIFO uses a separate count, so full and empty are unambiguous.

Reset
REQ-016 On rst_n low, asynchronously:
- State goes to IDLE and both FIFOs empty.
- The following outputs go to 0: outstanding_cnt, proto_err, perf counters, cpu_instr_ready, core_instr_valid, nmcu_resp_valid, core_resp_ready, drain_done.
REQ-017 Reset mid-transfer SHALL discard all buffered entries. cpu_instr_ready and core_resp_ready rise on the first clk edge after rst_n deasserts.

Configuration
REQ-018 With macro NMCU_LINK_PERF_EN defined:
- perf_instr_cnt SHALL increment on each CPU handshake.
- perf_stall_cnt SHALL increment on each cycle with cpu_instr_valid high and cpu_instr_ready low.
- Both counters are 32-bit and wrap at 2^32.
REQ-019 Without NMCU_LINK_PERF_EN, both perf ports SHALL exist and be tied to 0, with no counter flops.

Structure
REQ-020 instruction_t and nmcu_cpu_resp_t SHALL remain in instr_pkg. instr_pkg SHALL also hold:
- link_state_t, an enum of IDLE, ACTIVE, DRAIN and DRAINED.
- Default constants for INSTR_FIFO_DEPTH, RESP_FIFO_DEPTH and MAX_OUTSTANDING.
REQ-021 A generic sub-module sync_fifo SHALL provide storage. It is parameterised by type and depth and instantiated twice, once for ingress and once for responses.

Verification
REQ-022 Reset, then instruction A at cycle 0 with core_instr_ready=1 -> core_instr_valid=1 with payload A at cycle 1, and outstanding_cnt=1.
REQ-023 core_instr_ready=0, 5 back-to-back instructions, depth 4 -> 4 accepted, then cpu_instr_ready=0. Pop one -> ready returns the next cycle. perf_stall_cnt counts the stalled cycles (with the macro).
REQ-024 MAX_OUTSTANDING=2, responses withheld -> third instruction stalls. One nmcu_resp handshake -> the third is accepted, and outstanding_cnt goes 2 -> 1 -> 2.
REQ-025 Core response with outstanding_cnt=0 -> proto_err=1 persisting, response delivered, outstanding_cnt stays 0.
REQ-026 drain_req=1 with 3 outstanding -> cpu_instr_ready=0 immediately. After 3 responses, drain_done=1. drain_req=0 -> IDLE, and ready returns.
REQ-027 Assert rst_n=0 with both FIFOs holding entries -> all valids and counters are 0 asynchronously, and no stale entry appears after reset.
